// File: rtl/picosoc_regs_ctrl.sv
// Register-file sequencer for the PicoSoC core: clears all 32 registers after reset,
// then shares the write port and read port 2 between the CPU and a debug host.
module picosoc_regs_ctrl #(
  parameter int MAX_WAIT       = 4,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_wen,
  input  logic [5:0]  cpu_waddr,
  input  logic [31:0] cpu_wdata,
  input  logic [5:0]  cpu_raddr1,
  input  logic [5:0]  cpu_raddr2,
  input  logic        cpu_rd2_en,
  output logic [31:0] cpu_rdata1,
  output logic [31:0] cpu_rdata2,
  output logic        cpu_stall,
  input  logic        dbg_valid,
  input  logic        dbg_write,
  input  logic [4:0]  dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_ready,
  output logic [31:0] dbg_rdata,
  output logic        init_done,
  output logic        rf_wen,
  output logic [5:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [5:0]  rf_raddr1,
  output logic [5:0]  rf_raddr2,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2
);

  typedef enum logic [1:0] {INIT, IDLE, ACK} state_t;

  localparam logic [3:0] STARVE_MAX = 4'(MAX_WAIT);

  state_t      state;
  logic [4:0]  clr_cnt;
  logic [3:0]  starve;
  logic        port_free;
  logic        grant;
  logic        forced;

  assign rf_raddr1  = cpu_raddr1;
  assign cpu_rdata1 = rf_rdata1;
  assign cpu_rdata2 = rf_rdata2;
  assign dbg_ready  = (state == ACK) && !reset;

  // A forced grant steals a port the CPU is actively using, so the CPU must stall.
  always_comb begin
    port_free = dbg_write ? !cpu_wen : !cpu_rd2_en;
    grant     = (state == IDLE) && dbg_valid && (port_free || (starve == STARVE_MAX));
    forced    = grant && !port_free;
  end

  always_comb begin
    rf_wen    = cpu_wen;
    rf_waddr  = cpu_waddr;
    rf_wdata  = cpu_wdata;
    rf_raddr2 = cpu_raddr2;
    cpu_stall = 1'b0;
    if (state == INIT) begin
      rf_wen    = 1'b1;
      rf_waddr  = {1'b0, clr_cnt};
      rf_wdata  = '0;
      cpu_stall = 1'b1;
    end else if (grant) begin
      if (dbg_write) begin
        rf_wen   = (dbg_addr != 5'd0);
        rf_waddr = {1'b0, dbg_addr};
        rf_wdata = dbg_wdata;
      end else begin
        rf_raddr2 = {1'b0, dbg_addr};
        // A stalled CPU replays its whole request next cycle, so drop its write now.
        if (forced) rf_wen = 1'b0;
      end
      if (forced) cpu_stall = 1'b1;
    end
    if (reset) begin
      rf_wen    = 1'b0;
      cpu_stall = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= CLEAR_ON_RESET ? INIT : IDLE;
      init_done <= !CLEAR_ON_RESET;
      dbg_rdata <= '0;
      starve    <= '0;
      clr_cnt   <= '0;
    end else begin
      case (state)
        INIT: begin
          clr_cnt <= clr_cnt + 5'd1;
          if (clr_cnt == 5'd31) begin
            init_done <= 1'b1;
            state     <= IDLE;
          end
        end
        IDLE: begin
          if (grant) begin
            starve <= '0;
            state  <= ACK;
            if (!dbg_write) dbg_rdata <= rf_rdata2;
          end else if (!dbg_valid) begin
            starve <= '0;
          end else if (starve != STARVE_MAX) begin
            starve <= starve + 4'd1;
          end
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_picosoc_regs_ctrl.sv
// Directed bench for picosoc_regs_ctrl with a behavioural 32x32 register file
// attached to the rf_* ports so clears, writes and reads can be observed end to end.
module tb_picosoc_regs_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_wen;
  logic [5:0]  cpu_waddr;
  logic [31:0] cpu_wdata;
  logic [5:0]  cpu_raddr1;
  logic [5:0]  cpu_raddr2;
  logic        cpu_rd2_en;
  logic [31:0] cpu_rdata1;
  logic [31:0] cpu_rdata2;
  logic        cpu_stall;
  logic        dbg_valid;
  logic        dbg_write;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_ready;
  logic [31:0] dbg_rdata;
  logic        init_done;
  logic        rf_wen;
  logic [5:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [5:0]  rf_raddr1;
  logic [5:0]  rf_raddr2;
  logic [31:0] rf_rdata1;
  logic [31:0] rf_rdata2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  picosoc_regs_ctrl #(.MAX_WAIT(4), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .reset(reset),
    .cpu_wen(cpu_wen), .cpu_waddr(cpu_waddr), .cpu_wdata(cpu_wdata),
    .cpu_raddr1(cpu_raddr1), .cpu_raddr2(cpu_raddr2), .cpu_rd2_en(cpu_rd2_en),
    .cpu_rdata1(cpu_rdata1), .cpu_rdata2(cpu_rdata2), .cpu_stall(cpu_stall),
    .dbg_valid(dbg_valid), .dbg_write(dbg_write), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_ready(dbg_ready), .dbg_rdata(dbg_rdata),
    .init_done(init_done),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2)
  );

  // Register file model; starts with junk so the clear sequence is visible.
  logic [31:0] regs [32] = '{default: 32'hBAD0_BAD0};
  always @(posedge clk) if (rf_wen) regs[rf_waddr[4:0]] <= rf_wdata;
  assign rf_rdata1 = regs[rf_raddr1[4:0]];
  assign rf_rdata2 = regs[rf_raddr2[4:0]];

  typedef struct {
    logic        cpu_wen;
    logic [5:0]  cpu_waddr;
    logic [31:0] cpu_wdata;
    logic        cpu_rd2_en;
    logic [5:0]  cpu_raddr2;
    logic        dbg_valid;
    logic        dbg_write;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic        exp_rf_wen;
    logic [5:0]  exp_rf_waddr;
    logic [31:0] exp_rf_wdata;
    logic [5:0]  exp_rf_raddr2;
    logic        exp_stall;
    logic        exp_ready;
    logic [31:0] exp_dbg_rdata;
  } vec_t;

  vec_t vecs [22];
  vec_t v;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t s);
    cpu_wen    = s.cpu_wen;
    cpu_waddr  = s.cpu_waddr;
    cpu_wdata  = s.cpu_wdata;
    cpu_rd2_en = s.cpu_rd2_en;
    cpu_raddr2 = s.cpu_raddr2;
    dbg_valid  = s.dbg_valid;
    dbg_write  = s.dbg_write;
    dbg_addr   = s.dbg_addr;
    dbg_wdata  = s.dbg_wdata;
  endtask

  // One cycle: drive after the edge, compare at the falling edge, then clock.
  task automatic runVec(input vec_t s, input string tag);
    applyStimulus(s);
    @(negedge clk);
    checkOutput({tag, ".rf_wen"},    32'(rf_wen),    32'(s.exp_rf_wen));
    checkOutput({tag, ".rf_waddr"},  32'(rf_waddr),  32'(s.exp_rf_waddr));
    checkOutput({tag, ".rf_wdata"},  rf_wdata,       s.exp_rf_wdata);
    checkOutput({tag, ".rf_raddr2"}, 32'(rf_raddr2), 32'(s.exp_rf_raddr2));
    checkOutput({tag, ".cpu_stall"}, 32'(cpu_stall), 32'(s.exp_stall));
    checkOutput({tag, ".dbg_ready"}, 32'(dbg_ready), 32'(s.exp_ready));
    checkOutput({tag, ".dbg_rdata"}, dbg_rdata,      s.exp_dbg_rdata);
    @(posedge clk);
    #1;
  endtask

  task automatic clearCycle(input int idx, input string tag);
    @(negedge clk);
    checkOutput($sformatf("%s%0d.rf_wen", tag, idx),    32'(rf_wen),    32'd1);
    checkOutput($sformatf("%s%0d.rf_waddr", tag, idx),  32'(rf_waddr),  32'(idx));
    checkOutput($sformatf("%s%0d.rf_wdata", tag, idx),  rf_wdata,       32'd0);
    checkOutput($sformatf("%s%0d.cpu_stall", tag, idx), 32'(cpu_stall), 32'd1);
    checkOutput($sformatf("%s%0d.init_done", tag, idx), 32'(init_done), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    cpu_wen = 1'b0; cpu_waddr = '0; cpu_wdata = '0; cpu_raddr1 = '0;
    cpu_raddr2 = '0; cpu_rd2_en = 1'b0;
    dbg_valid = 1'b0; dbg_write = 1'b0; dbg_addr = '0; dbg_wdata = '0;

    //          cwen  cwaddr cwdata        rd2en raddr2 dval  dwr   daddr  dwdata        e_wen e_waddr e_wdata      e_raddr2 e_stl e_rdy e_rdata
    vecs[0]  = '{1'b1, 6'd3, 32'h0000_0111, 1'b0, 6'd7, 1'b0, 1'b0, 5'd0, 32'h0,         1'b1, 6'd3,  32'h0000_0111, 6'd7,  1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 6'd3, 32'h0000_0111, 1'b0, 6'd7, 1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1, 6'd5,  32'hDEAD_BEEF, 6'd7,  1'b0, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 6'd3, 32'h0000_0111, 1'b0, 6'd9, 1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 6'd3,  32'h0000_0111, 6'd9,  1'b0, 1'b1, 32'h0};
    vecs[3]  = '{1'b0, 6'd3, 32'h0000_0111, 1'b0, 6'd9, 1'b1, 1'b0, 5'd5, 32'h0,         1'b0, 6'd3,  32'h0000_0111, 6'd5,  1'b0, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 6'd3, 32'h0000_0111, 1'b0, 6'd9, 1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 6'd3,  32'h0000_0111, 6'd9,  1'b0, 1'b1, 32'hDEAD_BEEF};
    vecs[5]  = '{1'b0, 6'd3, 32'h0000_0111, 1'b0, 6'd9, 1'b1, 1'b1, 5'd0, 32'h1234_5678, 1'b0, 6'd0,  32'h1234_5678, 6'd9,  1'b0, 1'b0, 32'hDEAD_BEEF};
    vecs[6]  = '{1'b0, 6'd3, 32'h0000_0111, 1'b0, 6'd9, 1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 6'd3,  32'h0000_0111, 6'd9,  1'b0, 1'b1, 32'hDEAD_BEEF};
    vecs[7]  = '{1'b0, 6'd3, 32'h0000_0111, 1'b0, 6'd9, 1'b1, 1'b0, 5'd0, 32'h0,         1'b0, 6'd3,  32'h0000_0111, 6'd0,  1'b0, 1'b0, 32'hDEAD_BEEF};
    vecs[8]  = '{1'b0, 6'd3, 32'h0000_0111, 1'b0, 6'd9, 1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 6'd3,  32'h0000_0111, 6'd9,  1'b0, 1'b1, 32'h0};
    vecs[9]  = '{1'b0, 6'd3, 32'h0000_0111, 1'b1, 6'd9, 1'b1, 1'b0, 5'd3, 32'h0,         1'b0, 6'd3,  32'h0000_0111, 6'd9,  1'b0, 1'b0, 32'h0};
    vecs[10] = '{1'b0, 6'd3, 32'h0000_0111, 1'b0, 6'd9, 1'b1, 1'b0, 5'd3, 32'h0,         1'b0, 6'd3,  32'h0000_0111, 6'd3,  1'b0, 1'b0, 32'h0};
    vecs[11] = '{1'b0, 6'd3, 32'h0000_0111, 1'b0, 6'd9, 1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 6'd3,  32'h0000_0111, 6'd9,  1'b0, 1'b1, 32'h0000_0111};
    vecs[12] = '{1'b0, 6'd3, 32'h0000_0111, 1'b0, 6'd9, 1'b1, 1'b0, 5'd5, 32'h0,         1'b0, 6'd3,  32'h0000_0111, 6'd5,  1'b0, 1'b0, 32'h0000_0111};
    vecs[13] = '{1'b0, 6'd3, 32'h0000_0111, 1'b0, 6'd9, 1'b1, 1'b0, 5'd5, 32'h0,         1'b0, 6'd3,  32'h0000_0111, 6'd9,  1'b0, 1'b1, 32'hDEAD_BEEF};
    vecs[14] = '{1'b0, 6'd3, 32'h0000_0111, 1'b0, 6'd9, 1'b1, 1'b0, 5'd5, 32'h0,         1'b0, 6'd3,  32'h0000_0111, 6'd5,  1'b0, 1'b0, 32'hDEAD_BEEF};
    vecs[15] = '{1'b0, 6'd3, 32'h0000_0111, 1'b0, 6'd9, 1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 6'd3,  32'h0000_0111, 6'd9,  1'b0, 1'b1, 32'hDEAD_BEEF};
    vecs[16] = '{1'b1, 6'd5, 32'h0000_CAFE, 1'b0, 6'd9, 1'b1, 1'b0, 5'd5, 32'h0,         1'b1, 6'd5,  32'h0000_CAFE, 6'd5,  1'b0, 1'b0, 32'hDEAD_BEEF};
    vecs[17] = '{1'b0, 6'd3, 32'h0000_0111, 1'b0, 6'd9, 1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 6'd3,  32'h0000_0111, 6'd9,  1'b0, 1'b1, 32'hDEAD_BEEF};
    vecs[18] = '{1'b0, 6'd3, 32'h0000_0111, 1'b0, 6'd9, 1'b1, 1'b0, 5'd5, 32'h0,         1'b0, 6'd3,  32'h0000_0111, 6'd5,  1'b0, 1'b0, 32'hDEAD_BEEF};
    vecs[19] = '{1'b0, 6'd3, 32'h0000_0111, 1'b0, 6'd9, 1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 6'd3,  32'h0000_0111, 6'd9,  1'b0, 1'b1, 32'h0000_CAFE};
    vecs[20] = '{1'b0, 6'd3, 32'h0000_0111, 1'b1, 6'd9, 1'b1, 1'b1, 5'd7, 32'h0000_0077, 1'b1, 6'd7,  32'h0000_0077, 6'd9,  1'b0, 1'b0, 32'h0000_CAFE};
    vecs[21] = '{1'b0, 6'd3, 32'h0000_0111, 1'b0, 6'd9, 1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 6'd3,  32'h0000_0111, 6'd9,  1'b0, 1'b1, 32'h0000_CAFE};

    $display("[TB] reset and clear sequence");
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    checkOutput("rst.rf_wen",    32'(rf_wen),    32'd0);
    checkOutput("rst.cpu_stall", 32'(cpu_stall), 32'd1);
    checkOutput("rst.dbg_ready", 32'(dbg_ready), 32'd0);
    checkOutput("rst.init_done", 32'(init_done), 32'd0);
    checkOutput("rst.dbg_rdata", dbg_rdata,      32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 17; i++) clearCycle(i, "clrA");
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midrst.rf_wen",    32'(rf_wen),    32'd0);
    checkOutput("midrst.cpu_stall", 32'(cpu_stall), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 32; i++) clearCycle(i, "clrB");

    @(negedge clk);
    checkOutput("post.init_done", 32'(init_done), 32'd1);
    checkOutput("post.cpu_stall", 32'(cpu_stall), 32'd0);
    checkOutput("post.rf_wen",    32'(rf_wen),    32'd0);
    for (int i = 0; i < 32; i++) begin
      cpu_raddr1 = {i[0], i[4:0]};
      @(negedge clk);
      checkOutput($sformatf("zero%0d.cpu_rdata1", i), cpu_rdata1, 32'd0);
    end
    @(posedge clk); #1;

    $display("[TB] table vectors");
    for (int i = 0; i < 22; i++) runVec(vecs[i], $sformatf("vec%0d", i));

    $display("[TB] forced debug write");
    v = '{1'b1, 6'd10, 32'h0000_AAAA, 1'b0, 6'd9, 1'b1, 1'b1, 5'd12, 32'h0000_5555,
          1'b1, 6'd10, 32'h0000_AAAA, 6'd9, 1'b0, 1'b0, 32'h0000_CAFE};
    for (int k = 0; k < 4; k++) runVec(v, $sformatf("fw_block%0d", k));
    v.exp_rf_waddr = 6'd12; v.exp_rf_wdata = 32'h0000_5555; v.exp_stall = 1'b1;
    runVec(v, "fw_grant");
    v.exp_rf_waddr = 6'd10; v.exp_rf_wdata = 32'h0000_AAAA; v.exp_stall = 1'b0; v.exp_ready = 1'b1;
    runVec(v, "fw_ack");

    $display("[TB] forced debug read");
    v = '{1'b0, 6'd3, 32'h0000_0111, 1'b1, 6'd9, 1'b1, 1'b0, 5'd12, 32'h0,
          1'b0, 6'd3, 32'h0000_0111, 6'd9, 1'b0, 1'b0, 32'h0000_CAFE};
    for (int k = 0; k < 4; k++) runVec(v, $sformatf("fr_block%0d", k));
    v.exp_rf_raddr2 = 6'd12; v.exp_stall = 1'b1;
    runVec(v, "fr_grant");
    v.dbg_valid = 1'b0; v.exp_rf_raddr2 = 6'd9; v.exp_stall = 1'b0; v.exp_ready = 1'b1;
    v.exp_dbg_rdata = 32'h0000_5555;
    runVec(v, "fr_ack");

    $display("[TB] register readback");
    cpu_rd2_en = 1'b0; cpu_wen = 1'b0;
    cpu_raddr1 = 6'd10; @(negedge clk); checkOutput("rb10.cpu_rdata1", cpu_rdata1, 32'h0000_AAAA);
    cpu_raddr1 = 6'd12; @(negedge clk); checkOutput("rb12.cpu_rdata1", cpu_rdata1, 32'h0000_5555);
    cpu_raddr1 = 6'd7;  @(negedge clk); checkOutput("rb7.cpu_rdata1",  cpu_rdata1, 32'h0000_0077);
    cpu_raddr1 = 6'd3;  @(negedge clk); checkOutput("rb3.cpu_rdata1",  cpu_rdata1, 32'h0000_0111);
    cpu_raddr1 = 6'd5;  @(negedge clk); checkOutput("rb5.cpu_rdata1",  cpu_rdata1, 32'h0000_CAFE);
    cpu_raddr1 = 6'd0;  @(negedge clk); checkOutput("rb0.cpu_rdata1",  cpu_rdata1, 32'h0);
    cpu_raddr2 = 6'd12; @(negedge clk); checkOutput("rb12.cpu_rdata2", cpu_rdata2, 32'h0000_5555);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
